// File: rtl/fetch_unit.sv
// fetch_unit: request/response instruction fetch engine with a small prefetch
// FIFO and a full RV32I branch/jump resolver. At most one fetch is outstanding;
// a taken, word-aligned control-flow result from execute flushes the FIFO and
// restarts fetch at the resolved target.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_link,
  output logic            misalign
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            misalign_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            misaligned_now;
  logic            pop;
  logic            push;
  logic            issue;
  logic            fifo_full;

  // Resolver: evaluate the branch condition and the control-flow target.
  always_comb begin
    cond     = 1'b0;
    taken    = 1'b0;
    jalr_sum = ex_rs1 + ex_imm;
    target   = ex_pc + ex_imm;
    case (ex_funct3)
      3'b000:  cond = (ex_rs1 == ex_rs2);
      3'b001:  cond = (ex_rs1 != ex_rs2);
      3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond = (ex_rs1 <  ex_rs2);
      3'b111:  cond = (ex_rs1 >= ex_rs2);
      default: cond = 1'b0;
    endcase
    case (ex_kind)
      2'd1:    taken = cond;
      2'd2:    taken = 1'b1;
      2'd3: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  // A taken target with bit 1 set is reported instead of followed.
  assign redirect       = ex_valid & taken & ~target[1];
  assign misaligned_now = ex_valid & taken &  target[1];
  assign ex_link        = ex_pc + XLEN'(4);

  assign fifo_full   = (count_reg == CW'(DEPTH));
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign push        = (state_reg == WAIT) & imem_rvalid & ~redirect;
  // A pop in the same cycle frees a slot, so a full FIFO can still fetch.
  assign issue       = ~rst & (state_reg == ISSUE) & ~redirect & (~fifo_full | pop);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_reg;
  assign instr     = instr_valid ? fifo_instr[rd_ptr_reg] : '0;
  assign instr_pc  = instr_valid ? fifo_pc[rd_ptr_reg]    : '0;
  assign misalign  = misalign_reg;

  // Fetch sequencer: one request in flight, stale responses dropped after redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ISSUE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_reg <= target;
      case (state_reg)
        WAIT, DISCARD: state_reg <= imem_rvalid ? ISSUE : DISCARD;
        default:       state_reg <= ISSUE;
      endcase
    end else begin
      case (state_reg)
        ISSUE: begin
          if (issue) begin
            req_pc_reg   <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            state_reg    <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state_reg <= ISSUE;
        DISCARD: if (imem_rvalid) state_reg <= ISSUE;
        default: state_reg <= ISSUE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: each response is stored with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_reg] <= imem_rdata;
      fifo_pc[wr_ptr_reg]    <= req_pc_reg;
    end
  end

  // Misaligned-target report, one cycle after the offending execute op.
  always_ff @(posedge clk) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= misaligned_now;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset values, sequential fetch, backpressure, a
// resolver vector table, redirect/reset corner sequences and a randomized run
// checked by a stream-level reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ex_valid = 1'b0;
  logic [1:0]  ex_kind = 2'd0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_pc = 32'h0, ex_rs1 = 32'h0, ex_rs2 = 32'h0, ex_imm = 32'h0;
  logic [31:0] ex_link;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .ex_valid(ex_valid), .ex_kind(ex_kind), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_link(ex_link), .misalign(misalign)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Reference resolver, written from the control-flow rules.
  typedef struct packed { logic taken; logic [31:0] target; } res_t;
  function automatic res_t ref_resolve(input logic [1:0] kind, input logic [2:0] f3,
                                       input logic [31:0] pc, rs1, rs2, imm);
    res_t r;
    logic [31:0] s;
    int a, b;
    s = rs1 + imm;
    a = rs1;
    b = rs2;
    r.target = (kind == 2'd3) ? (s & ~32'h1) : (pc + imm);
    r.taken  = 1'b0;
    if (kind == 2'd2 || kind == 2'd3) r.taken = 1'b1;
    else if (kind == 2'd1) begin
      case (f3)
        3'd0: r.taken = (rs1 == rs2);
        3'd1: r.taken = (rs1 != rs2);
        3'd4: r.taken = (a < b);
        3'd5: r.taken = !(a < b);
        3'd6: r.taken = (rs1 < rs2);
        3'd7: r.taken = !(rs1 < rs2);
        default: r.taken = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Instruction memory model: latency sampled at request time, plus an injector
  // for an unsolicited response.
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        inj = 1'b0;

  always @(posedge clk) begin
    if (rst) mem_pend <= 1'b0;
    else if (imem_req) begin
      mem_pend <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= imem_addr;
    end else if (mem_pend) begin
      if (mem_cnt == 0) mem_pend <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end
  end

  assign imem_rvalid = (mem_pend && mem_cnt == 0) || inj;
  assign imem_rdata  = inj ? 32'hDEAD_BEEF : word_of(mem_addr);

  // Stream monitor: accepted instructions must follow the expected program
  // order, restarting at each redirect target.
  logic [31:0] exp_pc = RESET_PC;
  int          req_cnt = 0, acc_cnt = 0;
  logic        mis_exp = 1'b0, hold_prev = 1'b0;
  logic [31:0] hold_instr = 32'h0, hold_pc = 32'h0;
  res_t        mon_r;
  logic        mon_redir;

  always @(negedge clk) begin
    mon_r     = ref_resolve(ex_kind, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm);
    mon_redir = ex_valid && mon_r.taken && !mon_r.target[1];
    if (rst) begin
      exp_pc = RESET_PC; req_cnt = 0; acc_cnt = 0; mis_exp = 1'b0; hold_prev = 1'b0;
    end else begin
      chk("mon_misalign", misalign, mis_exp);
      if (hold_prev) begin
        chk("mon_hold_valid", instr_valid, 1'b1);
        chk("mon_hold_instr", instr, hold_instr);
        chk("mon_hold_pc", instr_pc, hold_pc);
      end
      if (mon_redir) exp_pc = mon_r.target;
      else if (instr_valid && instr_ready) begin
        chk("mon_stream_pc", instr_pc, exp_pc);
        chk("mon_stream_instr", instr, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        acc_cnt++;
      end
      if (imem_req) req_cnt++;
      mis_exp    = ex_valid && mon_r.taken && mon_r.target[1];
      hold_prev  = instr_valid && !instr_ready && !mon_redir;
      hold_instr = instr;
      hold_pc    = instr_pc;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_misalign"}, misalign, 1'b0);
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      #1;
      if (imem_req) seen = 1'b1;
    end
    chk({tag, "_req_timeout"}, seen, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        taken;
    logic [31:0] target;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] k, input logic [2:0] f,
                               input logic [31:0] pc, rs1, rs2, imm,
                               input logic t, input logic [31:0] tg);
    vec_t v;
    v.kind = k; v.f3 = f; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.taken = t; v.target = tg;
    return v;
  endfunction

  vec_t tbl[30];

  initial begin
    logic [31:0] prev_addr;
    int acc0;
    res_t r;

    // Resolver table: hand-derived rows, then model-computed random rows.
    tbl[0]  = mkv(2'd1, 3'd4, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1, 32'h50);
    tbl[1]  = mkv(2'd1, 3'd6, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0, 32'h50);
    tbl[2]  = mkv(2'd3, 3'd0, 32'h60, 32'h103, 32'h0, 32'h0, 1'b1, 32'h102);
    tbl[3]  = mkv(2'd3, 3'd0, 32'h60, 32'h101, 32'h0, 32'h0, 1'b1, 32'h100);
    tbl[4]  = mkv(2'd1, 3'd0, 32'h200, 32'h7, 32'h7, 32'hFFFF_FFF8, 1'b1, 32'h1F8);
    tbl[5]  = mkv(2'd1, 3'd1, 32'h200, 32'h7, 32'h7, 32'hFFFF_FFF8, 1'b0, 32'h1F8);
    tbl[6]  = mkv(2'd1, 3'd2, 32'h200, 32'h7, 32'h7, 32'h8, 1'b0, 32'h208);
    tbl[7]  = mkv(2'd2, 3'd0, 32'h80, 32'h0, 32'h0, 32'h20, 1'b1, 32'hA0);
    tbl[8]  = mkv(2'd0, 3'd0, 32'h80, 32'h5, 32'h5, 32'h20, 1'b0, 32'hA0);
    tbl[9]  = mkv(2'd1, 3'd5, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h12, 1'b0, 32'h312);
    tbl[10] = mkv(2'd1, 3'd7, 32'h300, 32'hFFFF_FFFF, 32'h1, 32'h12, 1'b1, 32'h312);
    tbl[11] = mkv(2'd2, 3'd0, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20, 1'b1, 32'h10);
    tbl[12] = mkv(2'd3, 3'd0, 32'h500, 32'h1001, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h1000);
    tbl[13] = mkv(2'd1, 3'd3, 32'h10, 32'h1, 32'h1, 32'h4, 1'b0, 32'h14);
    for (int i = 14; i < 30; i++) begin
      vec_t v;
      v.kind = 2'($urandom_range(0, 3));
      v.f3   = 3'($urandom_range(0, 7));
      v.pc   = $urandom & 32'h0000_FFFC;
      v.rs1  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF);
      v.rs2  = ($urandom_range(0, 2) == 0) ? v.rs1 : $urandom;
      v.imm  = 32'($urandom_range(0, 511) * 2) - 32'd512;
      r = ref_resolve(v.kind, v.f3, v.pc, v.rs1, v.rs2, v.imm);
      v.taken  = r.taken;
      v.target = r.target;
      tbl[i] = v;
    end

    // Reset values.
    repeat (3) cyc();
    #1;
    check_reset_outputs("reset");

    // Sequential fetch with 1-cycle memory and decode always ready.
    cyc();
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      #1;
      chk("seq_req", imem_req, 32'(c % 2 == 0));
      if (c % 2 == 0) chk("seq_addr", imem_addr, 32'(4 * (c / 2)));
      chk("seq_valid", instr_valid, 32'(c >= 2 && c % 2 == 0));
      if (c >= 2 && c % 2 == 0) chk("seq_pc", instr_pc, 32'(4 * (c / 2 - 1)));
    end

    // Backpressure: decode stalls, FIFO fills to DEPTH and fetch stops.
    cyc();
    instr_ready = 1'b0;
    repeat (10) cyc();
    #1;
    chk("bp_req", imem_req, 1'b0);
    chk("bp_valid", instr_valid, 1'b1);
    chk("bp_buffered", 32'(req_cnt - acc_cnt), 32'(DEPTH));
    cyc();
    instr_ready = 1'b1;
    #1;
    chk("bp_release0_valid", instr_valid, 1'b1);
    cyc();
    #1;
    chk("bp_release1_valid", instr_valid, 1'b1);
    repeat (8) cyc();

    // Resolver table, applied with the FIFO full and fetch idle.
    instr_ready = 1'b0;
    repeat (8) cyc();
    for (int i = 0; i < 30; i++) begin
      cyc();
      ex_valid = 1'b1; ex_kind = tbl[i].kind; ex_funct3 = tbl[i].f3;
      ex_pc = tbl[i].pc; ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2; ex_imm = tbl[i].imm;
      #1;
      chk("tbl_link", ex_link, tbl[i].pc + 32'd4);
      prev_addr = imem_addr;
      cyc();
      ex_valid = 1'b0;
      #1;
      chk("tbl_misalign", misalign, tbl[i].taken & tbl[i].target[1]);
      if (tbl[i].taken && !tbl[i].target[1]) begin
        chk("tbl_target", imem_addr, tbl[i].target);
        chk("tbl_redirect_req", imem_req, 1'b1);
        chk("tbl_flush", instr_valid, 1'b0);
      end else begin
        chk("tbl_no_redirect_addr", imem_addr, prev_addr);
        chk("tbl_keep", instr_valid, 1'b1);
      end
      cyc();
      #1;
      chk("tbl_misalign_pulse", misalign, 1'b0);
      repeat (6) cyc();
    end

    // Redirect while a 3-cycle request is outstanding.
    instr_ready = 1'b1;
    lat = 3;
    wait_req("wait_redir");
    cyc();
    ex_valid = 1'b1; ex_kind = 2'd2; ex_pc = 32'h3F0; ex_imm = 32'h10;
    #1;
    chk("wr_k1_req", imem_req, 1'b0);
    cyc();
    ex_valid = 1'b0;
    #1;
    chk("wr_k2_valid", instr_valid, 1'b0);
    chk("wr_k2_req", imem_req, 1'b0);
    cyc();
    #1;
    chk("wr_k3_req", imem_req, 1'b0);
    cyc();
    #1;
    chk("wr_k4_req", imem_req, 1'b1);
    chk("wr_k4_addr", imem_addr, 32'h400);
    chk("wr_k4_valid", instr_valid, 1'b0);
    repeat (12) cyc();

    // Reset while a request is outstanding, then an unsolicited response.
    wait_req("rst_mid");
    cyc();
    rst = 1'b1;
    cyc();
    #1;
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    inj = 1'b1;
    lat = 1;
    #1;
    chk("rst_restart_req", imem_req, 1'b1);
    chk("rst_restart_addr", imem_addr, RESET_PC);
    cyc();
    inj = 1'b0;
    #1;
    chk("rst_stale_ignored", instr_valid, 1'b0);
    cyc();
    #1;
    chk("rst_first_valid", instr_valid, 1'b1);
    chk("rst_first_pc", instr_pc, RESET_PC);
    chk("rst_first_instr", instr, word_of(RESET_PC));

    // Randomized traffic: variable latency, stalls and control-flow ops.
    acc0 = acc_cnt;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      instr_ready = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) begin
        ex_valid  = 1'b1;
        ex_kind   = 2'($urandom_range(0, 3));
        ex_funct3 = 3'($urandom_range(0, 7));
        ex_pc     = $urandom & 32'h0000_FFFC;
        ex_rs1    = $urandom & 32'h0000_FFFF;
        ex_rs2    = ($urandom_range(0, 2) == 0) ? ex_rs1 : ($urandom & 32'h0000_FFFF);
        ex_imm    = 32'($urandom_range(0, 255) * 2) - 32'd256;
      end else begin
        ex_valid = 1'b0;
      end
    end
    cyc();
    ex_valid = 1'b0;
    repeat (4) cyc();
    chk("rand_progress", 32'(acc_cnt - acc0 > 100), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
